// File: rtl/mole_game_controller_if.sv
// Player-facing signal bundle for the mole game sequencer.
// Carries the start/button/random inputs and the LED, score and pulse outputs.
// The slave modport is the controller side; the master modport is the driver side.
interface mole_game_controller_if #(
  parameter int SCORE_W = 8
);
  logic               start;
  logic [7:0]         btn;
  logic [9:0]         rnd;
  logic [7:0]         led;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] misses;
  logic [7:0]         round_cnt;
  logic               hit_pulse;
  logic               miss_pulse;
  logic               game_over;

  modport slave (
    input  start,
    input  btn,
    input  rnd,
    output led,
    output score,
    output misses,
    output round_cnt,
    output hit_pulse,
    output miss_pulse,
    output game_over
  );

  modport master (
    output start,
    output btn,
    output rnd,
    input  led,
    input  score,
    input  misses,
    input  round_cnt,
    input  hit_pulse,
    input  miss_pulse,
    input  game_over
  );
endinterface

// File: rtl/mole_game_controller.sv
// Whack-a-mole sequencer: raises one of 8 moles from the random source and scores button hits/misses.
// Button/start edges take effect two clocks after first being sampled; all outputs are registered.
// No backpressure: inputs are sampled every cycle, stray presses outside a raised mole are dropped.
module mole_game_controller #(
  parameter int MOLE_TIME  = 50_000_000,
  parameter int GAP_TIME   = 25_000_000,
  parameter int NUM_ROUNDS = 16,
  parameter int SCORE_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mole_game_controller_if.slave bus
);

  // Timer is shared between the gap and mole phases, so size it for the longer one.
  localparam int TMAX = (MOLE_TIME > GAP_TIME) ? MOLE_TIME : GAP_TIME;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] MOLE_LOAD = TW'(MOLE_TIME - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_TIME - 1);
  localparam logic [7:0]    ROUND_END = 8'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_UP,
    ST_DONE
  } state_t;

  // Input conditioning flops: two-stage synchronizer plus one history stage.
  logic       start_s1_q, start_s2_q, start_h_q;
  logic [7:0] btn_s1_q, btn_s2_q, btn_h_q;

  // Game state and registered outputs.
  state_t             state_q;
  logic [TW-1:0]      timer_q;
  logic [2:0]         last_mole_q;
  logic [7:0]         led_q;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] misses_q;
  logic [7:0]         round_q;
  logic               hit_pulse_q;
  logic               miss_pulse_q;
  logic               game_over_q;

  // Combinational helpers feeding the state register.
  logic               start_rise;
  logic [7:0]         btn_rise;
  logic [2:0]         mole_d;
  logic [SCORE_W-1:0] score_d;
  logic [SCORE_W-1:0] misses_d;
  logic [7:0]         round_d;
  logic               timer_zero;
  logic               wrong_press;
  logic               right_press;
  logic               got_miss;
  logic               got_hit;
  logic               mole_end;
  logic               unused_rnd;

  // Only the low three bits of the random word choose the mole.
  assign unused_rnd = ^bus.rnd[9:3];

  // Synchronize the asynchronous switch/buttons and keep one cycle of history for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      start_h_q  <= 1'b0;
      btn_s1_q   <= 8'h00;
      btn_s2_q   <= 8'h00;
      btn_h_q    <= 8'h00;
    end else begin
      start_s1_q <= bus.start;
      start_s2_q <= start_s1_q;
      start_h_q  <= start_s2_q;
      btn_s1_q   <= bus.btn;
      btn_s2_q   <= btn_s1_q;
      btn_h_q    <= btn_s2_q;
    end
  end

  assign start_rise = start_s2_q & ~start_h_q;
  assign btn_rise   = btn_s2_q & ~btn_h_q;

  // Pick the next mole, stepping past the previous one so the same LED never repeats back to back.
  always_comb begin
    mole_d = bus.rnd[2:0];
    if (mole_d == last_mole_q) begin
      mole_d = mole_d + 3'd1;
    end
  end

  // Saturating counter increments and end-of-mole decision.
  always_comb begin
    score_d     = (&score_q)  ? score_q  : score_q + SCORE_W'(1);
    misses_d    = (&misses_q) ? misses_q : misses_q + SCORE_W'(1);
    round_d     = (round_q == ROUND_END) ? round_q : round_q + 8'd1;
    timer_zero  = (timer_q == '0);
    // led_q holds the one-hot mole while UP, so it doubles as the target mask.
    wrong_press = |(btn_rise & ~led_q);
    right_press = |(btn_rise & led_q);
    // A wrong button wins over the right one so mashing every button never scores.
    got_miss    = wrong_press | (~right_press & timer_zero);
    got_hit     = ~wrong_press & right_press;
    mole_end    = got_miss | got_hit;
  end

  // Game FSM with registered LED, counters and one-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      last_mole_q  <= 3'd0;
      led_q        <= 8'h00;
      score_q      <= '0;
      misses_q     <= '0;
      round_q      <= 8'h00;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          led_q <= 8'h00;
          if (start_rise) begin
            score_q     <= '0;
            misses_q    <= '0;
            round_q     <= 8'h00;
            timer_q     <= GAP_LOAD;
            game_over_q <= 1'b0;
            state_q     <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (timer_zero) begin
            last_mole_q <= mole_d;
            led_q       <= 8'h01 << mole_d;
            timer_q     <= MOLE_LOAD;
            state_q     <= ST_UP;
          end else begin
            led_q   <= 8'h00;
            timer_q <= timer_q - TW'(1);
          end
        end

        ST_UP: begin
          if (got_miss) begin
            misses_q     <= misses_d;
            miss_pulse_q <= 1'b1;
          end else if (got_hit) begin
            score_q     <= score_d;
            hit_pulse_q <= 1'b1;
          end else begin
            timer_q <= timer_q - TW'(1);
          end

          if (mole_end) begin
            led_q   <= 8'h00;
            round_q <= round_d;
            if (round_d == ROUND_END) begin
              game_over_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              timer_q <= GAP_LOAD;
              state_q <= ST_GAP;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          led_q   <= 8'h00;
        end
      endcase
    end
  end

  assign bus.led        = led_q;
  assign bus.score      = score_q;
  assign bus.misses     = misses_q;
  assign bus.round_cnt  = round_q;
  assign bus.hit_pulse  = hit_pulse_q;
  assign bus.miss_pulse = miss_pulse_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_mole_game_controller.sv
// Bench for mole_game_controller with short timing parameters.
// A phase/elapsed-time reference model is compared against the DUT on every falling edge.
// Directed scenarios add hand-computed checks on latency, repeat avoidance, priority and reset.
module tb_mole_game_controller;

  localparam int MOLE_TIME  = 20;
  localparam int GAP_TIME   = 5;
  localparam int NUM_ROUNDS = 4;
  localparam int SCORE_W    = 8;

  logic clk;
  logic rst_n;

  mole_game_controller_if #(.SCORE_W(SCORE_W)) dif();

  mole_game_controller #(
    .MOLE_TIME (MOLE_TIME),
    .GAP_TIME  (GAP_TIME),
    .NUM_ROUNDS(NUM_ROUNDS),
    .SCORE_W   (SCORE_W)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait budget expired at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 gap, 2 mole up, 3 done. Time in a phase is counted upward in edges.
  int         m_phase   = 0;
  int         m_elapsed = 0;
  int         m_mole    = 0;
  int         m_last    = 0;
  logic [7:0] b_h0 = 0, b_h1 = 0, b_h2 = 0;   // raw buttons at the previous 1/2/3 edges
  logic       s_h0 = 0, s_h1 = 0, s_h2 = 0;
  logic [7:0] e_led = 0;
  int         e_score = 0, e_misses = 0, e_round = 0;
  logic       e_hit = 0, e_miss = 0, e_over = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_elapsed = 0; m_mole = 0; m_last = 0;
        b_h0 = 0; b_h1 = 0; b_h2 = 0; s_h0 = 0; s_h1 = 0; s_h2 = 0;
        e_led = 0; e_score = 0; e_misses = 0; e_round = 0;
        e_hit = 0; e_miss = 0; e_over = 0;
      end else begin
        // A level first seen two edges ago, and absent three edges ago, is an edge acting now.
        logic [7:0] brise;
        logic       srise;
        logic [7:0] mask;
        logic       wrong, right, ended;
        brise = b_h1 & ~b_h2;
        srise = s_h1 & ~s_h2;
        b_h2 = b_h1; b_h1 = b_h0; b_h0 = dif.btn;
        s_h2 = s_h1; s_h1 = s_h0; s_h0 = dif.start;
        e_hit = 0;
        e_miss = 0;
        case (m_phase)
          0, 3: begin
            if (srise) begin
              e_score = 0; e_misses = 0; e_round = 0; e_over = 0;
              m_phase = 1; m_elapsed = 0;
            end
          end
          1: begin
            m_elapsed++;
            if (m_elapsed == GAP_TIME) begin
              m_mole = int'(dif.rnd[2:0]);
              if (m_mole == m_last) m_mole = (m_mole + 1) % 8;
              m_last = m_mole;
              e_led = 8'(1 << m_mole);
              m_phase = 2; m_elapsed = 0;
            end
          end
          default: begin
            m_elapsed++;
            mask  = 8'(1 << m_mole);
            wrong = (brise & ~mask) != 0;
            right = (brise & mask) != 0;
            ended = 0;
            if (wrong || (!right && m_elapsed == MOLE_TIME)) begin
              e_misses = (e_misses < 255) ? e_misses + 1 : 255;
              e_miss = 1; ended = 1;
            end else if (right) begin
              e_score = (e_score < 255) ? e_score + 1 : 255;
              e_hit = 1; ended = 1;
            end
            if (ended) begin
              e_led = 0;
              e_round++;
              if (e_round == NUM_ROUNDS) begin
                m_phase = 3; e_over = 1;
              end else begin
                m_phase = 1; m_elapsed = 0;
              end
            end
          end
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_led",       32'(dif.led),       32'(e_led));
      chk("cyc_score",     32'(dif.score),     32'(e_score));
      chk("cyc_misses",    32'(dif.misses),    32'(e_misses));
      chk("cyc_round",     32'(dif.round_cnt), 32'(e_round));
      chk("cyc_hit",       32'(dif.hit_pulse), 32'(e_hit));
      chk("cyc_miss",      32'(dif.miss_pulse),32'(e_miss));
      chk("cyc_game_over", 32'(dif.game_over), 32'(e_over));
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] g_leds [4];
  int         g_durs [4];
  int         g_pulses;

  task automatic pulse_start();
    dif.start = 1'b1;
    repeat (3) @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic wait_led(input string name);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (dif.led == 8'h00 && cyc < 200);
    if (dif.led == 8'h00) timeout_fail(name);
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!dif.game_over && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (!dif.game_over) timeout_fail(name);
  endtask

  // Plays a whole game without touching the buttons, recording each mole and how long it stayed up.
  task automatic play_idle_game(input logic [9:0] rv, input string name);
    int         idx, cyc;
    logic [7:0] prev;
    dif.rnd = rv;
    pulse_start();
    idx = 0; cyc = 0; prev = 8'h00; g_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      g_leds[i] = 8'h00;
      g_durs[i] = 0;
    end
    while (!dif.game_over && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (dif.miss_pulse) g_pulses++;
      if (dif.led != 8'h00) begin
        if (prev == 8'h00 && idx < 4) begin
          g_leds[idx] = dif.led;
          idx++;
        end
        if (idx > 0) g_durs[idx-1]++;
      end
      prev = dif.led;
    end
    if (!dif.game_over) timeout_fail(name);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst_n     = 1'b0;
    dif.start = 1'b0;
    dif.btn   = 8'h00;
    dif.rnd   = 10'd0;
    repeat (2) @(negedge clk);
    chk("rst_led",       32'(dif.led),        32'h0);
    chk("rst_score",     32'(dif.score),      32'h0);
    chk("rst_misses",    32'(dif.misses),     32'h0);
    chk("rst_round",     32'(dif.round_cnt),  32'h0);
    chk("rst_pulses",    32'({dif.hit_pulse, dif.miss_pulse}), 32'h0);
    chk("rst_game_over", 32'(dif.game_over),  32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: first mole at rnd=3, then a hit three edges after the press.
    dif.rnd   = 10'd3;
    dif.start = 1'b1;
    repeat (7) @(negedge clk);
    chk("t1_led_dark_in_gap", 32'(dif.led), 32'h00);
    @(negedge clk);
    chk("t1_led_up", 32'(dif.led), 32'h08);
    repeat (3) @(negedge clk);
    dif.btn = 8'h08;
    repeat (2) @(negedge clk);
    chk("t1_no_hit_yet", 32'(dif.hit_pulse), 32'h0);
    @(negedge clk);
    chk("t1_hit_pulse", 32'(dif.hit_pulse), 32'h1);
    chk("t1_score",     32'(dif.score),     32'h1);
    chk("t1_led_off",   32'(dif.led),       32'h00);
    chk("t1_round",     32'(dif.round_cnt), 32'h1);
    @(negedge clk);
    chk("t1_hit_one_cycle", 32'(dif.hit_pulse), 32'h0);
    dif.btn   = 8'h00;
    dif.start = 1'b0;
    wait_done("t1_done");
    chk("t1_end_score",  32'(dif.score),  32'h1);
    chk("t1_end_misses", 32'(dif.misses), 32'h3);

    // 2: untouched game, rnd=3: 3,4,3,4 each up for the full mole time.
    play_idle_game(10'd3, "t2_game");
    for (int i = 0; i < 4; i++) chk("t2_mole_duration", 32'(g_durs[i]), 32'd20);
    chk("t2_led0", 32'(g_leds[0]), 32'h08);
    chk("t2_led1", 32'(g_leds[1]), 32'h10);
    chk("t2_led2", 32'(g_leds[2]), 32'h08);
    chk("t2_led3", 32'(g_leds[3]), 32'h10);
    chk("t2_miss_pulses", 32'(g_pulses), 32'd4);
    chk("t2_misses",    32'(dif.misses),    32'd4);
    chk("t2_score",     32'(dif.score),     32'd0);
    chk("t2_game_over", 32'(dif.game_over), 32'h1);
    chk("t2_led_dark",  32'(dif.led),       32'h00);

    // 3: rnd=5 held: repeat avoidance alternates moles 5 and 6.
    play_idle_game(10'd5, "t3_game");
    chk("t3_led0", 32'(g_leds[0]), 32'h20);
    chk("t3_led1", 32'(g_leds[1]), 32'h40);
    chk("t3_led2", 32'(g_leds[2]), 32'h20);
    chk("t3_led3", 32'(g_leds[3]), 32'h40);

    // 4: mole 2 with btn[2] and btn[6] together is a miss; then a wrong button on mole 3.
    dif.rnd = 10'd2;
    pulse_start();
    wait_led("t4_mole_a");
    chk("t4_mole_is_2", 32'(dif.led), 32'h04);
    dif.btn = 8'h44;
    repeat (2) @(negedge clk);
    chk("t4_not_yet", 32'(dif.miss_pulse), 32'h0);
    @(negedge clk);
    chk("t4_misses",     32'(dif.misses),     32'd1);
    chk("t4_score",      32'(dif.score),      32'd0);
    chk("t4_miss_pulse", 32'(dif.miss_pulse), 32'h1);
    chk("t4_no_hit",     32'(dif.hit_pulse),  32'h0);
    dif.btn = 8'h00;
    wait_led("t4_mole_b");
    chk("t4_mole_is_3", 32'(dif.led), 32'h08);
    dif.btn = 8'h02;
    repeat (3) @(negedge clk);
    chk("t4_wrong_btn_miss", 32'(dif.misses), 32'd2);
    chk("t4_wrong_led_off",  32'(dif.led),    32'h00);
    dif.btn = 8'h00;

    // 5: correct press landing on the timeout edge scores; a press during the gap does nothing.
    wait_led("t5_mole");
    chk("t5_mole_is_2", 32'(dif.led), 32'h04);
    repeat (17) @(negedge clk);
    dif.btn = 8'h04;
    repeat (2) @(negedge clk);
    chk("t5_still_up", 32'(dif.led), 32'h04);
    @(negedge clk);
    chk("t5_hit_at_timeout", 32'(dif.hit_pulse),  32'h1);
    chk("t5_no_miss",        32'(dif.miss_pulse), 32'h0);
    chk("t5_score",          32'(dif.score),      32'd1);
    chk("t5_misses_hold",    32'(dif.misses),     32'd2);
    dif.btn = 8'h00;
    @(negedge clk);
    dif.btn = 8'h01;
    repeat (3) @(negedge clk);
    chk("t5_gap_press_score",  32'(dif.score),  32'd1);
    chk("t5_gap_press_misses", 32'(dif.misses), 32'd2);
    chk("t5_gap_press_pulses", 32'({dif.hit_pulse, dif.miss_pulse}), 32'h0);
    dif.btn = 8'h00;
    wait_done("t5_done");
    chk("t5_end_misses", 32'(dif.misses),    32'd3);
    chk("t5_end_round",  32'(dif.round_cnt), 32'd4);

    // 6: asynchronous reset mid-mole, then a restart from DONE clears the counters.
    dif.rnd = 10'd1;
    pulse_start();
    wait_led("t6_mole");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_led",    32'(dif.led),       32'h0);
    chk("t6_async_round",  32'(dif.round_cnt), 32'h0);
    chk("t6_async_over",   32'(dif.game_over), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    play_idle_game(10'd1, "t6_game");
    chk("t6_led0", 32'(g_leds[0]), 32'h02);
    chk("t6_led1", 32'(g_leds[1]), 32'h04);
    chk("t6_full_misses", 32'(dif.misses), 32'd4);
    dif.start = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_over_holds", 32'(dif.game_over), 32'h1);
    @(negedge clk);
    chk("t6_over_clear",   32'(dif.game_over), 32'h0);
    chk("t6_score_clear",  32'(dif.score),     32'h0);
    chk("t6_misses_clear", 32'(dif.misses),    32'h0);
    chk("t6_round_clear",  32'(dif.round_cnt), 32'h0);
    dif.start = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
